rom_loader: RTL

- Boot-time instruction-memory controller for the Hack CPU.
- Owns the write port and address mux of the 2048x16 instruction memory.
- On request, receives a framed program image over a byte stream (UART RX side) and writes it word by word, holding the CPU in reset for the whole load.
- When idle, passes the CPU program counter straight through to the memory address.

---
 rtl/hack_loader_pkg.sv | 38 +++
 rtl/loader_watchdog.sv | 52 +++++
 rtl/rom_loader.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/hack_loader_pkg.sv
// -----------------------------------------------------------------------------
// hack_loader_pkg
// Shared definitions for the Hack instruction-memory boot loader:
//   - state_t          : loader FSM state encoding
//   - HDR_BYTES        : length header size in bytes (big-endian word count)
//   - CHK_BYTES        : trailing checksum size in bytes
//   - DEFAULT_TIMEOUT  : default inter-byte watchdog limit in clk cycles
//   - frame_bytes()    : total frame size for a given word count
//   - len_ok()         : word-count validity for a given address width
// -----------------------------------------------------------------------------
package hack_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_HI  = 3'd1,
        LEN_LO  = 3'd2,
        DATA_HI = 3'd3,
        DATA_LO = 3'd4,
        CHK     = 3'd5,
        DONE    = 3'd6,
        ERR     = 3'd7
    } state_t;

    localparam int unsigned HDR_BYTES       = 2;
    localparam int unsigned CHK_BYTES       = 1;
    localparam int unsigned DEFAULT_TIMEOUT = 1000000;

    // Bytes on the wire for an N-word image: header + two bytes per word + checksum.
    function automatic int unsigned frame_bytes(input int unsigned n_words);
        return HDR_BYTES + 2 * n_words + CHK_BYTES;
    endfunction

    // A word count is loadable when it is non-zero and fits in 2^addr_w words.
    function automatic logic len_ok(input logic [15:0] n, input int unsigned addr_w);
        return (n != 16'd0) && ({16'd0, n} <= (32'd1 << addr_w));
    endfunction

endpackage

// File: rtl/loader_watchdog.sv
// -----------------------------------------------------------------------------
// loader_watchdog
// Inter-byte watchdog: a down-counter that is reloaded by i_clear and counts
// while i_enable is high. o_expire is high during the TIMEOUT-th enabled cycle
// after the last clear, so a consumer acting on it on the next edge reacts
// exactly TIMEOUT cycles after the clear. TIMEOUT=0 disables the watchdog.
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   i_clear   in   reload the counter (wins over counting and expiry)
//   i_enable  in   count this cycle
//   o_expire  out  limit reached this cycle
// -----------------------------------------------------------------------------
module loader_watchdog
    import hack_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic w_unused;
            assign w_unused = ^{clk, rst_n, i_clear, i_enable};
            assign o_expire = 1'b0;
        end else begin : g_on
            localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            // Loading TIMEOUT-1 makes the count read zero on the TIMEOUT-th cycle.
            localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

            logic [CW-1:0] r_count;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_count <= LOAD;
                end else if (i_clear) begin
                    r_count <= LOAD;
                end else if (i_enable && (r_count != '0)) begin
                    r_count <= r_count - CW'(1);
                end
            end

            assign o_expire = i_enable && !i_clear && (r_count == '0);
        end
    endgenerate

endmodule

// File: rtl/rom_loader.sv
// -----------------------------------------------------------------------------
// rom_loader
// Boot-time controller for the Hack instruction memory. Owns the memory write
// port and address mux. On start it receives a framed image over a byte
// stream (LEN_HI, LEN_LO, N x {hi, lo}, CHK = XOR of payload bytes) and writes
// it word by word while holding the CPU in reset. When not loading, the CPU
// program counter drives the memory address directly.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle load request (honoured in IDLE/DONE/ERR)
//   rx_valid   in   rx_data valid strobe
//   rx_data    in   received byte
//   cpu_pc     in   CPU fetch address
//   mem_addr   out  instruction-memory address
//   mem_wdata  out  instruction-memory write data
//   mem_we     out  instruction-memory write enable
//   cpu_hold   out  CPU reset/stall (loading or failed)
//   busy       out  load in progress
//   done       out  last load succeeded
//   error      out  last load failed
// -----------------------------------------------------------------------------
module rom_loader
    import hack_loader_pkg::*;
#(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic [15:0]       cpu_pc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // One extra bit so the index can reach N = 2^ADDR_W without wrapping.
    localparam int unsigned IDX_W = ADDR_W + 1;

    state_t            r_state;
    state_t            w_state_next;
    logic [15:0]       r_len;
    logic [7:0]        r_hi;
    logic [7:0]        r_chk;
    logic [IDX_W-1:0]  r_index;
    logic              r_we;
    logic [15:0]       r_wdata;

    logic              w_busy;
    logic              w_take;
    logic              w_start_ok;
    logic              w_expire;
    logic              w_len_ok;
    logic              w_last_word;

    assign w_busy      = (r_state == LEN_HI) || (r_state == LEN_LO) ||
                         (r_state == DATA_HI) || (r_state == DATA_LO) ||
                         (r_state == CHK);
    assign w_take      = w_busy && rx_valid;
    assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE) ||
                                   (r_state == ERR));
    assign w_len_ok    = len_ok({r_len[15:8], rx_data}, ADDR_W);
    // r_index still names the word being completed; the increment lands a cycle later.
    assign w_last_word = ((16'(r_index) + 16'd1) == r_len);

    // Reloaded while idle and on every accepted byte, so it only measures silence
    // inside a load.
    loader_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_take || !w_busy),
        .i_enable (w_busy),
        .o_expire (w_expire)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and status outputs
    always_comb begin
        w_state_next = r_state;
        busy         = w_busy;
        done         = 1'b0;
        error        = 1'b0;
        case (r_state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    w_state_next = LEN_HI;
                end
            end
            default: begin
                if (w_expire) begin
                    w_state_next = ERR;
                end else if (rx_valid) begin
                    case (r_state)
                        LEN_HI:  w_state_next = LEN_LO;
                        LEN_LO:  w_state_next = w_len_ok ? DATA_HI : ERR;
                        DATA_HI: w_state_next = DATA_LO;
                        DATA_LO: w_state_next = w_last_word ? CHK : DATA_HI;
                        CHK:     w_state_next = (rx_data == r_chk) ? DONE : ERR;
                        default: w_state_next = r_state;
                    endcase
                end
            end
        endcase
        if (r_state == DONE) begin
            done = 1'b1;
        end
        if (r_state == ERR) begin
            error = 1'b1;
        end
        // Held through a failed load so a partial image never runs.
        cpu_hold = w_busy || error;
    end

    // Datapath: length, word assembly, checksum, write strobe and index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len   <= '0;
            r_hi    <= '0;
            r_chk   <= '0;
            r_index <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_we <= 1'b0;
            if (r_we) begin
                r_index <= r_index + IDX_W'(1);
            end
            if (w_start_ok) begin
                r_index <= '0;
                r_chk   <= '0;
            end else if (w_take) begin
                case (r_state)
                    LEN_HI:  r_len[15:8] <= rx_data;
                    LEN_LO:  r_len[7:0]  <= rx_data;
                    DATA_HI: begin
                        r_hi  <= rx_data;
                        r_chk <= r_chk ^ rx_data;
                    end
                    DATA_LO: begin
                        r_chk   <= r_chk ^ rx_data;
                        r_we    <= 1'b1;
                        r_wdata <= {r_hi, rx_data};
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_we    = r_we;
    assign mem_wdata = r_wdata;
    assign mem_addr  = w_busy ? r_index[ADDR_W-1:0] : cpu_pc[ADDR_W-1:0];

    generate
        if (ADDR_W < 16) begin : g_pc_hi
            logic w_unused_pc;
            assign w_unused_pc = ^cpu_pc[15:ADDR_W];
        end
    endgenerate

endmodule
